// File: rtl/huff_pkg.sv
// Shared types and constants for the Huffman bit feeder.
package huff_pkg;
  localparam int WIN_W_DEF = 6;
  localparam int BYTE_W    = 8;
  localparam int CNT_W     = 5;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_RUN, S_DRAIN, S_DONE
  } feed_state_t;
endpackage

// File: rtl/huff_bit_feeder_if.sv
// Byte-in / window-out bundle between a stream source, the feeder and the Huffman decoder.
interface huff_bit_feeder_if
  import huff_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF
);
  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [WIN_W-1:0]  win_data;
  logic              win_valid;
  logic              win_last;
  logic              adv;
  logic [2:0]        adv_len;
  logic              flush;
  logic [CNT_W-1:0]  bit_count;
  logic              done;
  logic              adv_err;

  modport master (
    output in_data, in_valid, in_last, adv, adv_len, flush,
    input  in_ready, win_data, win_valid, win_last, bit_count, done, adv_err
  );
  modport slave (
    input  in_data, in_valid, in_last, adv, adv_len, flush,
    output in_ready, win_data, win_valid, win_last, bit_count, done, adv_err
  );
endinterface

// File: rtl/huff_bit_shifter.sv
// Shift-then-insert datapath: drop sh consumed bits, then append a byte after the survivors.
module huff_bit_shifter
  import huff_pkg::*;
#(
  parameter int BUF_W = 16
) (
  input  logic [BUF_W-1:0]  bits_q,
  input  logic [CNT_W-1:0]  count,
  input  logic [2:0]        sh,
  input  logic              ins,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [BUF_W-1:0]  bits_d,
  output logic [CNT_W-1:0]  count_d
);
  logic [CNT_W-1:0] rem;
  logic [BUF_W-1:0] ins_vec;

  always_comb begin
    rem     = count - CNT_W'(sh);
    ins_vec = '0;
    ins_vec[BUF_W-1 -: BYTE_W] = byte_in;
    bits_d  = bits_q << sh;
    count_d = rem;
    // Bits below the valid region are always zero, so OR-ing the byte in is safe.
    if (ins) begin
      bits_d  = bits_d | (ins_vec >> rem);
      count_d = rem + CNT_W'(BYTE_W);
    end
  end
endmodule

// File: rtl/huff_bit_feeder.sv
// Byte-to-bit feeder for a Huffman decoder: MSB-aligned window over a bit buffer.
// Optional HUFF_FEEDER_STATS_EN adds a saturating bits_consumed counter.
// BUF_W must be at least WIN_W+8.
module huff_bit_feeder
  import huff_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF,
  parameter int BUF_W = 16
) (
  input  logic clk,
  input  logic rst,
  huff_bit_feeder_if.slave bus
`ifdef HUFF_FEEDER_STATS_EN
  ,
  output logic [15:0] bits_consumed
`endif
);
  feed_state_t      state_q, state_d;
  logic [BUF_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             accept, legal;

  assign bus.in_ready  = (state_q != S_DRAIN) && (state_q != S_DONE) &&
                         (cnt_q <= CNT_W'(BUF_W - BYTE_W));
  assign bus.win_data  = bits_q[BUF_W-1 -: WIN_W];
  assign bus.win_valid = ((state_q == S_FILL || state_q == S_RUN) && cnt_q >= CNT_W'(WIN_W)) ||
                         (state_q == S_DRAIN && cnt_q != '0);
  assign bus.win_last  = (state_q == S_DRAIN) && (cnt_q <= CNT_W'(WIN_W));
  assign bus.bit_count = cnt_q;
  assign bus.done      = (state_q == S_DONE);
  assign bus.adv_err   = err_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign legal  = bus.adv && bus.win_valid && (bus.adv_len != 3'd0) &&
                  (CNT_W'(bus.adv_len) <= CNT_W'(WIN_W)) && (CNT_W'(bus.adv_len) <= cnt_q);

  huff_bit_shifter #(.BUF_W(BUF_W)) u_shift (
    .bits_q (bits_q),
    .count  (cnt_q),
    .sh     (legal ? bus.adv_len : 3'd0),
    .ins    (accept),
    .byte_in(bus.in_data),
    .bits_d (bits_d),
    .count_d(cnt_d)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q | (bus.adv && !legal);
    case (state_q)
      S_IDLE:  if (accept) state_d = S_FILL;
      S_FILL:  if (cnt_d >= CNT_W'(WIN_W)) state_d = S_RUN;
      S_RUN:   if (cnt_d <  CNT_W'(WIN_W)) state_d = S_FILL;
      S_DRAIN: if (cnt_d == '0) state_d = S_DONE;
      default: state_d = state_q;
    endcase
    if (accept && bus.in_last) state_d = S_DRAIN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      bits_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else if (bus.flush) begin
      state_q <= S_IDLE;
      bits_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef HUFF_FEEDER_STATS_EN
  logic [16:0] stat_sum;
  assign stat_sum = {1'b0, bits_consumed} + 17'(bus.adv_len);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                bits_consumed <= '0;
    else if (bus.flush)      bits_consumed <= '0;
    else if (legal)          bits_consumed <= stat_sum[16] ? 16'hFFFF : stat_sum[15:0];
  end
`endif
endmodule

// File: tb/tb_huff_bit_feeder.sv
module tb_huff_bit_feeder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  huff_bit_feeder_if #(.WIN_W(6)) bus ();
`ifdef HUFF_FEEDER_STATS_EN
  logic [15:0] bits_consumed;
`endif

  huff_bit_feeder #(.WIN_W(6), .BUF_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef HUFF_FEEDER_STATS_EN
    , .bits_consumed(bits_consumed)
`endif
  );

  always #5 clk = ~clk;

  task automatic ck(input bit ok, input string tag);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic last);
    bus.in_data = d; bus.in_valid = 1'b1; bus.in_last = last;
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic advance(input logic [2:0] n);
    bus.adv = 1'b1; bus.adv_len = n;
    tick();
    bus.adv = 1'b0; bus.adv_len = 3'd0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  initial begin
    bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.adv = 1'b0; bus.adv_len = 3'd0; bus.flush = 1'b0;
    #12;
    ck(bus.bit_count === 5'd0, "rst_count");
    ck(bus.win_data === 6'd0, "rst_win_data");
    ck(bus.win_valid === 1'b0, "rst_win_valid");
    ck(bus.win_last === 1'b0, "rst_win_last");
    ck(bus.done === 1'b0, "rst_done");
    ck(bus.adv_err === 1'b0, "rst_adv_err");
    rst = 1'b1;
    tick();
    ck(bus.in_ready === 1'b1, "rel_in_ready");

    push(8'hA5, 1'b0);
    ck(bus.win_data === 6'b101001, "a5_win_data");
    ck(bus.win_valid === 1'b1, "a5_win_valid");
    ck(bus.bit_count === 5'd8, "a5_count");
    advance(3'd1);
    ck(bus.win_data === 6'b010010, "adv1_win_data");
    ck(bus.bit_count === 5'd7, "adv1_count");
    do_flush();

    push(8'hA5, 1'b0);
    bus.in_data = 8'h3C; bus.in_valid = 1'b1; bus.adv = 1'b1; bus.adv_len = 3'd4;
    tick();
    bus.in_valid = 1'b0; bus.adv = 1'b0; bus.adv_len = 3'd0;
    ck(bus.bit_count === 5'd12, "both_count");
    ck(bus.win_data === 6'b010100, "both_win_data");
`ifdef HUFF_FEEDER_STATS_EN
    ck(bits_consumed === 16'd4, "stats_after_4");
`endif
    do_flush();
    ck(bus.bit_count === 5'd0, "flush_count");

    push(8'hFF, 1'b0);
    push(8'h00, 1'b0);
    ck(bus.bit_count === 5'd16, "full_count");
    ck(bus.in_ready === 1'b0, "full_in_ready");
    advance(3'd6);
    ck(bus.bit_count === 5'd10, "full_adv6_count");
    ck(bus.in_ready === 1'b0, "full_adv6_ready");
    ck(bus.win_data === 6'b110000, "full_adv6_win");
    advance(3'd2);
    ck(bus.bit_count === 5'd8, "full_adv2_count");
    ck(bus.in_ready === 1'b1, "full_adv2_ready");
    ck(bus.win_data === 6'b000000, "full_adv2_win");
    do_flush();

    push(8'h80, 1'b1);
    ck(bus.win_data === 6'b100000, "last_win_data");
    ck(bus.in_ready === 1'b0, "last_in_ready");
    ck(bus.win_last === 1'b0, "last_win_last");
    advance(3'd6);
    ck(bus.bit_count === 5'd2, "drain_count");
    ck(bus.win_data === 6'd0, "drain_win_data");
    ck(bus.win_valid === 1'b1, "drain_win_valid");
    ck(bus.win_last === 1'b1, "drain_win_last");
    ck(bus.done === 1'b0, "drain_done");
    advance(3'd2);
    ck(bus.done === 1'b1, "done_done");
    ck(bus.win_valid === 1'b0, "done_win_valid");
    ck(bus.bit_count === 5'd0, "done_count");
    tick();
    ck(bus.done === 1'b1, "done_hold");
    do_flush();
    ck(bus.done === 1'b0, "flush_done");

    advance(3'd1);
    ck(bus.adv_err === 1'b1, "err_novalid");
    ck(bus.bit_count === 5'd0, "err_novalid_count");
    do_flush();
    ck(bus.adv_err === 1'b0, "err_flush");
    push(8'hA5, 1'b0);
    advance(3'd7);
    ck(bus.adv_err === 1'b1, "err_len7");
    ck(bus.bit_count === 5'd8, "err_len7_count");
    ck(bus.win_data === 6'b101001, "err_len7_win");
    advance(3'd1);
    ck(bus.adv_err === 1'b1, "err_sticky");
    do_flush();
    ck(bus.adv_err === 1'b0, "err_flush2");
    ck(bus.win_valid === 1'b0, "flush_idle_valid");
    ck(bus.in_ready === 1'b1, "flush_idle_ready");

    push(8'hA5, 1'b0);
    bus.in_data = 8'h3C; bus.in_valid = 1'b1; bus.adv = 1'b1; bus.adv_len = 3'd4;
    tick();
    bus.in_valid = 1'b0; bus.adv = 1'b0; bus.adv_len = 3'd0;
    ck(bus.bit_count === 5'd12, "pre_rst_count");
    #2 rst = 1'b0;
    #1;
    ck(bus.bit_count === 5'd0, "arst_count");
    ck(bus.win_data === 6'd0, "arst_win_data");
    ck(bus.win_valid === 1'b0, "arst_win_valid");
    ck(bus.done === 1'b0, "arst_done");
`ifdef HUFF_FEEDER_STATS_EN
    ck(bits_consumed === 16'd0, "arst_stats");
`endif
    #3 rst = 1'b1;
    tick();
    ck(bus.in_ready === 1'b1, "post_rst_ready");
    ck(bus.bit_count === 5'd0, "post_rst_count");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/huff_bit_feeder.md
HUFF_BIT_FEEDER -- requirements
Module: huff_bit_feeder

Interface
REQ-001 SHALL have parameter WIN_W, default 6, meaning window width in bits presented to the Huffman decoder.
REQ-002 SHALL have parameter BUF_W, default 16, meaning bit-buffer depth; legal only if BUF_W >= WIN_W+8.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  8  byte of encoded bitstream, MSB is first bit.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_last  input  1  qualifies in_data as final byte of stream.
REQ-008 in_ready  output  1  feeder accepts a byte this cycle.
REQ-009 win_data  output  WIN_W  next WIN_W unconsumed bits, MSB-aligned.
REQ-010 win_valid  output  1  win_data holds valid bits.
REQ-011 win_last  output  1  fewer than WIN_W+1 valid bits remain after final byte.
REQ-012 adv  input  1  consume adv_len bits from window.
REQ-013 adv_len  input  3  number of bits to consume, 1..WIN_W.
REQ-014 flush  input  1  synchronous clear of buffer and state.
REQ-015 bit_count  output  5  valid bits currently buffered.
REQ-016 done  output  1  stream fully consumed.
REQ-017 adv_err  output  1  sticky illegal-advance flag.

Function
REQ-018 SHALL implement states IDLE, FILL, RUN, DRAIN, DONE.
REQ-019 Transitions: IDLE->FILL on first byte accept; FILL->RUN when bit_count>=WIN_W; RUN->FILL when bit_count<WIN_W; any->DRAIN on accept with in_last; DRAIN->DONE when bit_count reaches 0.
REQ-020 Byte accept occurs when in_valid && in_ready; in_ready = (state not DRAIN/DONE) && bit_count <= BUF_W-8, from registered count only.
REQ-021 Accepted byte SHALL be appended directly after the last valid bit; visible on win_data the next cycle.
REQ-022 win_valid SHALL be bit_count>=WIN_W in FILL/RUN, bit_count>0 in DRAIN, 0 in IDLE/DONE.
REQ-023 Unfilled bit positions of win_data SHALL read 0.
REQ-024 Legal advance: adv && win_valid && 1<=adv_len<=WIN_W && adv_len<=bit_count; buffer shifts left by adv_len, bit_count decrements by adv_len.
REQ-025 Simultaneous accept and legal advance SHALL shift first, then append byte at position bit_count-adv_len; bit_count_next = bit_count-adv_len+8.
REQ-026 Illegal advance SHALL leave buffer and count unchanged and set adv_err until flush or reset.
REQ-027 win_last SHALL be 1 only in DRAIN with bit_count<=WIN_W.
REQ-028 done SHALL be 1 only in DONE; DONE holds until flush or reset.
REQ-029 flush SHALL have priority over accept and advance; next cycle equals post-reset state.

Reset
REQ-030 On rst low: state IDLE, buffer 0, bit_count 0, win_data 0, win_valid 0, win_last 0, done 0, adv_err 0; in_ready 1 after release.
REQ-031 Reset mid-stream SHALL discard all buffered bits with no partial output.

Configuration
REQ-032 Macro HUFF_FEEDER_STATS_EN: when defined, SHALL add output bits_consumed (16-bit, saturating at 0xFFFF) counting legal-advance bits, cleared by reset/flush; when undefined, port and counter absent.

Structure
REQ-033 Package huff_pkg SHALL hold WIN_W default, BYTE_W=8, and the feeder state enum typedef.
REQ-034 Sub-module huff_bit_shifter SHALL implement the combinational shift-and-insert datapath; FSM and counters stay in huff_bit_feeder.

Verification
REQ-035 Accept 0xA5 from reset -> next cycle win_data=101001, win_valid=1, bit_count=8; adv_len=1 -> win_data=010010, bit_count=7.
REQ-036 bit_count=8 holding 0xA5, same cycle adv_len=4 and accept 0x3C -> bit_count=12, win_data=010100.
REQ-037 Accept 0xFF then 0x00 -> bit_count=16, in_ready=0; adv 6 -> 10, in_ready=0; adv 2 -> 8, in_ready=1.
REQ-038 Accept 0x80 with in_last -> DRAIN, win_data=100000; adv 6 -> bit_count=2, win_data=000000, win_valid=1, win_last=1; adv 2 -> done=1, win_valid=0.
REQ-039 adv_len=7, or adv with win_valid=0 -> adv_err=1, bit_count unchanged; flush -> adv_err=0, state IDLE.
REQ-040 rst asserted with bit_count=12 -> all outputs at reset values same cycle; with HUFF_FEEDER_STATS_EN, bits_consumed=0.
